// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 register file: register numbers, SR bit layout
// and the mask of SR bits software can actually hold.
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int IM_LO   = 10;
    localparam int IM_HI   = 15;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;

    localparam int IM_W = IM_HI - IM_LO + 1;

    localparam logic [31:0] SR_MASK = 32'h0000_FC03;

endpackage

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file (SR, Cause, EPC, PRId) and interrupt request gate for the
// multicycle core; handles MTC0/MFC0 plus the interrupt entry and ERET side effects.
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID   = 32'h4C59_0001,
    parameter logic [31:0] SR_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Sel,
    input  logic [31:0] DIn,
    input  logic [29:0] PC,
    input  logic [5:0]  HWInt,
    input  logic        Wen,
    input  logic        EXLSet,
    input  logic        EXLClr,
    input  logic        EPCWr,
    output logic        IntReq,
    output logic [29:0] EPC,
    output logic [31:0] DOut
);

    logic [31:0]     sr_reg;
    logic [IM_W-1:0] ip_reg;
    logic [29:0]     epc_reg;
    logic            mtc0_we;
    logic [IM_W-1:0] int_hit;

    // Any controller side-effect strobe suppresses the plain MTC0 write.
    assign mtc0_we = Wen & ~EXLSet & ~EXLClr & ~EPCWr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_reg  <= SR_RST & SR_MASK;
            ip_reg  <= '0;
            epc_reg <= '0;
        end else begin
            ip_reg <= HWInt;

            if (EXLSet)
                sr_reg[EXL_BIT] <= 1'b1;
            else if (EXLClr)
                sr_reg[EXL_BIT] <= 1'b0;
            else if (mtc0_we && Sel == CP0_SR)
                sr_reg <= DIn & SR_MASK;

            if (EPCWr)
                epc_reg <= PC;
            else if (mtc0_we && Sel == CP0_EPC)
                epc_reg <= DIn[31:2];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < IM_W; gi++) begin : g_hit
            assign int_hit[gi] = ip_reg[gi] & sr_reg[IM_LO + gi];
        end
    endgenerate

    assign IntReq = (|int_hit) & sr_reg[IE_BIT] & ~sr_reg[EXL_BIT];
    assign EPC    = epc_reg;

    always_comb begin
        DOut = 32'h0;
        case (Sel)
            CP0_SR:    DOut = sr_reg;
            CP0_CAUSE: DOut = {16'h0, ip_reg, 10'h0};
            CP0_EPC:   DOut = {epc_reg, 2'b00};
            CP0_PRID:  DOut = PRID;
            default:   DOut = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: reset, MTC0/MFC0, interrupt gating, entry, ERET and
// same-cycle collisions, each checked against hand-computed values.
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Sel;
    logic [31:0] DIn;
    logic [29:0] PC;
    logic [5:0]  HWInt;
    logic        Wen, EXLSet, EXLClr, EPCWr;
    logic        IntReq;
    logic [29:0] EPC;
    logic [31:0] DOut;

    int n_asserts = 0;
    int n_fail    = 0;

    cp0_regfile dut (
        .clk    (clk),
        .rst    (rst),
        .Sel    (Sel),
        .DIn    (DIn),
        .PC     (PC),
        .HWInt  (HWInt),
        .Wen    (Wen),
        .EXLSet (EXLSet),
        .EXLClr (EXLClr),
        .EPCWr  (EPCWr),
        .IntReq (IntReq),
        .EPC    (EPC),
        .DOut   (DOut)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
            $display("check %-14s observed %08h expected %08h ok", tag, obs, exp);
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] sel, input string tag, input logic [31:0] exp);
        Sel = sel;
        #1;
        chk(tag, DOut, exp);
    endtask

    task automatic clr_strobes();
        Wen = 0; EXLSet = 0; EXLClr = 0; EPCWr = 0;
    endtask

    task automatic mtc0(input logic [4:0] sel, input logic [31:0] d);
        Sel = sel; DIn = d; Wen = 1;
        step();
        clr_strobes();
    endtask

    initial begin
        rst = 1; Sel = 0; DIn = 0; PC = 0; HWInt = 6'h3F;
        clr_strobes();

        // Reset for two cycles with all interrupt lines high.
        step();
        step();
        rst = 0;
        rd(5'd12, "rst_sr", 32'h0);
        rd(5'd13, "rst_cause", 32'h0);
        rd(5'd14, "rst_epc_rd", 32'h0);
        chk("rst_epc", {2'b0, EPC}, 32'h0);
        chk("rst_intreq", {31'b0, IntReq}, 32'h0);
        step();
        rd(5'd13, "cause_ip", 32'h0000_FC00);

        // MTC0 / MFC0.
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd(5'd12, "sr_mask", 32'h0000_FC03);
        chk("exl_gate", {31'b0, IntReq}, 32'h0);
        mtc0(5'd14, 32'h0000_3008);
        chk("epc_write", {2'b0, EPC}, 32'h0000_0C02);
        rd(5'd14, "epc_read", 32'h0000_3008);
        rd(5'd15, "prid", 32'h4C59_0001);
        mtc0(5'd13, 32'h0);
        rd(5'd13, "cause_ro", 32'h0000_FC00);
        rd(5'd3, "unmapped", 32'h0);

        // Gating.
        HWInt = 6'h00;
        mtc0(5'd12, 32'h0000_0401);
        step();
        chk("gate_idle", {31'b0, IntReq}, 32'h0);
        HWInt = 6'h01;
        #1;
        chk("gate_lat0", {31'b0, IntReq}, 32'h0);
        step();
        chk("gate_lat1", {31'b0, IntReq}, 32'h1);
        mtc0(5'd12, 32'h0000_0400);
        chk("gate_ie0", {31'b0, IntReq}, 32'h0);
        mtc0(5'd12, 32'h0000_0801);
        chk("gate_im0", {31'b0, IntReq}, 32'h0);
        mtc0(5'd12, 32'h0000_0403);
        chk("gate_exl1", {31'b0, IntReq}, 32'h0);
        mtc0(5'd12, 32'h0000_0401);
        chk("gate_on", {31'b0, IntReq}, 32'h1);

        // Interrupt entry.
        PC = 30'h0C05; DIn = 32'hDEAD_BEEF; Sel = 5'd12;
        Wen = 1; EXLSet = 1; EPCWr = 1;
        #1;
        chk("rbw_sr", DOut, 32'h0000_0401);
        chk("epc_nobypass", {2'b0, EPC}, 32'h0000_0C02);
        step();
        clr_strobes();
        chk("entry_epc", {2'b0, EPC}, 32'h0000_0C05);
        rd(5'd12, "entry_sr", 32'h0000_0403);
        chk("entry_intreq", {31'b0, IntReq}, 32'h0);

        // ERET with the interrupt still pending.
        Sel = 5'd12; DIn = 32'hFFFF_FFFF; Wen = 1; EXLClr = 1;
        step();
        clr_strobes();
        rd(5'd12, "eret_sr", 32'h0000_0401);
        chk("eret_epc", {2'b0, EPC}, 32'h0000_0C05);
        chk("eret_intreq", {31'b0, IntReq}, 32'h1);

        // Collisions.
        Sel = 5'd12; DIn = 32'h0; Wen = 1; EXLSet = 1;
        step();
        clr_strobes();
        rd(5'd12, "coll_set_mtc0", 32'h0000_0403);
        Wen = 1; EXLSet = 1; EXLClr = 1;
        step();
        clr_strobes();
        rd(5'd12, "coll_set_clr", 32'h0000_0403);
        Sel = 5'd14; DIn = 32'hFFFF_FFFF; PC = 30'h1234; Wen = 1; EPCWr = 1;
        step();
        clr_strobes();
        chk("coll_epcwr", {2'b0, EPC}, 32'h0000_1234);
        rst = 1; EXLSet = 1; EPCWr = 1; Wen = 1;
        step();
        rst = 0;
        clr_strobes();
        rd(5'd12, "rst_over_set", 32'h0);
        chk("rst_over_epc", {2'b0, EPC}, 32'h0);

        // HWInt dropping: no sticky pending state.
        mtc0(5'd12, 32'h0000_0401);
        chk("drop_on", {31'b0, IntReq}, 32'h1);
        HWInt = 6'h00;
        step();
        chk("drop_off", {31'b0, IntReq}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
